// File: rtl/alu_b_operand_stage.sv
// alu_b_operand_stage
//   ID/EX operand-B stage for the pipelined core. It picks ALU operand B from
//   the rs2 value, the immediate, the constant 4, or zero. The rs2 value is
//   forwarded from EX/MEM or MEM/WB. The result is registered into the ID/EX
//   boundary, with flush taking priority over stall, and stall over load.
//   The forwarded rs2 value is also registered as store data. A saturating
//   counter records how many loaded, valid instructions used a forward.
//
// Build option:
//   ALU_B_FWD_EN  when defined, the forwarding logic and fwd_cnt are present.
//                 When undefined, rs2 comes straight from the register file,
//                 fwd_sel is tied to 00 and fwd_cnt is tied to 0.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid, stall, flush      pipeline control
//   aluBSrc                     00 rs2, 01 immgen, 10 const 4, 11 zero
//   rs2_addr, ru_rs2, immgen    decode-stage operands
//   exmem_wen/rd/result         EX/MEM writeback request
//   memwb_wen/rd/result         MEM/WB writeback request
//   cnt_clr                     synchronous clear of fwd_cnt
//   aluB, store_data            registered operand B and forwarded rs2
//   out_valid, fwd_sel          registered valid and forwarding source
//   fwd_cnt                     saturating count of forwarded instructions
module alu_b_operand_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [1:0]      aluBSrc,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [XLEN-1:0] ru_rs2,
    input  logic [XLEN-1:0] immgen,
    input  logic            exmem_wen,
    input  logic [AW-1:0]   exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_wen,
    input  logic [AW-1:0]   memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    input  logic            cnt_clr,
    output logic [XLEN-1:0] aluB,
    output logic [XLEN-1:0] store_data,
    output logic            out_valid,
    output logic [1:0]      fwd_sel,
    output logic [CNTW-1:0] fwd_cnt
);

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_e;

    typedef enum logic [1:0] {
        SRC_RS2  = 2'b00,
        SRC_IMM  = 2'b01,
        SRC_FOUR = 2'b10,
        SRC_ZERO = 2'b11
    } bsrc_e;

    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] alub_nxt;
    fwd_e            sel_nxt;

`ifdef ALU_B_FWD_EN
    logic ex_hit;
    logic mw_hit;
    logic load;

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    always_comb begin
        ex_hit  = exmem_wen && (exmem_rd == rs2_addr) && (rs2_addr != '0);
        mw_hit  = memwb_wen && (memwb_rd == rs2_addr) && (rs2_addr != '0);
        rs2_fwd = ru_rs2;
        sel_nxt = FWD_NONE;
        if (ex_hit) begin
            rs2_fwd = exmem_result;
            sel_nxt = FWD_EXMEM;
        end else if (mw_hit) begin
            rs2_fwd = memwb_result;
            sel_nxt = FWD_MEMWB;
        end
    end

    assign load = !flush && !stall;

    // The count follows the computed rs2 forward, not aluBSrc, because store
    // data consumes the forward even when operand B is an immediate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt <= '0;
        end else if (cnt_clr) begin
            fwd_cnt <= '0;
        end else if (load && in_valid && (sel_nxt != FWD_NONE) && (fwd_cnt != '1)) begin
            fwd_cnt <= fwd_cnt + 1'b1;
        end
    end
`else
    logic unused_fwd;

    always_comb begin
        rs2_fwd = ru_rs2;
        sel_nxt = FWD_NONE;
    end

    assign fwd_cnt    = '0;
    assign unused_fwd = ^{exmem_wen, exmem_rd, exmem_result,
                          memwb_wen, memwb_rd, memwb_result, cnt_clr};
`endif

    always_comb begin
        alub_nxt = '0;
        case (bsrc_e'(aluBSrc))
            SRC_RS2:  alub_nxt = rs2_fwd;
            SRC_IMM:  alub_nxt = immgen;
            SRC_FOUR: alub_nxt = XLEN'(4);
            SRC_ZERO: alub_nxt = '0;
            default:  alub_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluB       <= '0;
            store_data <= '0;
            out_valid  <= 1'b0;
            fwd_sel    <= FWD_NONE;
        end else if (flush) begin
            aluB       <= '0;
            store_data <= '0;
            out_valid  <= 1'b0;
            fwd_sel    <= FWD_NONE;
        end else if (!stall) begin
            aluB       <= alub_nxt;
            store_data <= rs2_fwd;
            out_valid  <= in_valid;
            fwd_sel    <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_alu_b_operand_stage.sv
module tb_alu_b_operand_stage;

`ifdef ALU_B_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int CMAX = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, flush, cnt_clr;
    logic [1:0]  aluBSrc;
    logic [4:0]  rs2_addr, exmem_rd, memwb_rd;
    logic [31:0] ru_rs2, immgen, exmem_result, memwb_result;
    logic        exmem_wen, memwb_wen;
    logic [31:0] aluB, store_data;
    logic        out_valid;
    logic [1:0]  fwd_sel;
    logic [3:0]  fwd_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_alub, m_sd;
    logic        m_v;
    logic [1:0]  m_sel;
    int          m_cnt;

    alu_b_operand_stage #(.XLEN(32), .AW(5), .CNTW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .aluBSrc(aluBSrc), .rs2_addr(rs2_addr), .ru_rs2(ru_rs2), .immgen(immgen),
        .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_wen(memwb_wen), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .cnt_clr(cnt_clr), .aluB(aluB), .store_data(store_data), .out_valid(out_valid),
        .fwd_sel(fwd_sel), .fwd_cnt(fwd_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        v;
        logic [1:0]  src;
        logic [4:0]  rs2;
        logic [31:0] ru, imm;
        logic        exw;
        logic [4:0]  exrd;
        logic [31:0] exr;
        logic        mww;
        logic [4:0]  mwrd;
        logic [31:0] mwr;
        logic [31:0] e_alub, e_sd;
        logic [1:0]  e_sel;
    } vec_t;

    vec_t tbl[8];

    function automatic vec_t mkv(logic v, logic [1:0] src, logic [4:0] rs2, logic [31:0] ru,
                                 logic [31:0] imm, logic exw, logic [4:0] exrd, logic [31:0] exr,
                                 logic mww, logic [4:0] mwrd, logic [31:0] mwr,
                                 logic [31:0] e_alub, logic [31:0] e_sd, logic [1:0] e_sel);
        vec_t r;
        r.v = v; r.src = src; r.rs2 = rs2; r.ru = ru; r.imm = imm;
        r.exw = exw; r.exrd = exrd; r.exr = exr; r.mww = mww; r.mwrd = mwrd; r.mwr = mwr;
        r.e_alub = e_alub; r.e_sd = e_sd; r.e_sel = e_sel;
        // Without forwarding hardware the rs2 value is always the register-file read.
        if (!FWD) begin
            r.e_sd  = ru;
            r.e_sel = 2'b00;
            if (src == 2'b00) r.e_alub = ru;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_alub = 0; m_sd = 0; m_v = 0; m_sel = 0; m_cnt = 0;
    endtask

    // Reference behaviour for one clock edge, from the current input values.
    task automatic model_edge();
        logic [31:0] f, b;
        logic [1:0]  s;
        f = ru_rs2;
        s = 2'd0;
        if (FWD && rs2_addr != 0) begin
            if (exmem_wen && exmem_rd == rs2_addr) begin f = exmem_result; s = 2'd1; end
            else if (memwb_wen && memwb_rd == rs2_addr) begin f = memwb_result; s = 2'd2; end
        end
        case (aluBSrc)
            2'd0: b = f;
            2'd1: b = immgen;
            2'd2: b = 32'd4;
            default: b = 32'd0;
        endcase
        if (FWD) begin
            if (cnt_clr) m_cnt = 0;
            else if (!flush && !stall && in_valid && s != 0) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        end
        if (flush) begin
            m_alub = 0; m_sd = 0; m_v = 0; m_sel = 0;
        end else if (!stall) begin
            m_alub = b; m_sd = f; m_v = in_valid; m_sel = s;
        end
    endtask

    task automatic edge_chk(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, ".aluB"}, aluB, m_alub);
        chk({tag, ".store_data"}, store_data, m_sd);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_v});
        chk({tag, ".fwd_sel"}, {30'd0, fwd_sel}, {30'd0, m_sel});
        chk({tag, ".fwd_cnt"}, {28'd0, fwd_cnt}, m_cnt);
    endtask

    task automatic quiet();
        in_valid = 0; stall = 0; flush = 0; cnt_clr = 0; aluBSrc = 0;
        rs2_addr = 0; ru_rs2 = 0; immgen = 0;
        exmem_wen = 0; exmem_rd = 0; exmem_result = 0;
        memwb_wen = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic randomize_inputs();
        in_valid     = 1'($urandom);
        aluBSrc      = 2'($urandom);
        rs2_addr     = 5'($urandom_range(0, 3));
        ru_rs2       = $urandom;
        immgen       = $urandom;
        exmem_wen    = 1'($urandom);
        exmem_rd     = 5'($urandom_range(0, 3));
        exmem_result = $urandom;
        memwb_wen    = 1'($urandom);
        memwb_rd     = 5'($urandom_range(0, 3));
        memwb_result = $urandom;
    endtask

    task automatic set_fwd_load(input logic [4:0] r, input logic [31:0] val);
        quiet();
        in_valid = 1; aluBSrc = 2'b00; rs2_addr = r; ru_rs2 = 32'h0BAD_0000;
        exmem_wen = 1; exmem_rd = r; exmem_result = val;
    endtask

    initial begin
        // Reset with arbitrary inputs driven.
        rst_n = 0;
        quiet();
        randomize_inputs();
        stall = 0;
        model_reset();
        #12;
        chk("reset.aluB", aluB, 0);
        chk("reset.store_data", store_data, 0);
        chk("reset.out_valid", {31'd0, out_valid}, 0);
        chk("reset.fwd_sel", {30'd0, fwd_sel}, 0);
        chk("reset.fwd_cnt", {28'd0, fwd_cnt}, 0);
        @(posedge clk); #1;
        rst_n = 1;

        // Directed single-cycle vectors.
        tbl[0] = mkv(1, 2'b01, 5'd3, 32'h11, 32'h0000_0800, 0, 5'd0, 0, 0, 5'd0, 0,
                     32'h800, 32'h11, 2'b00);
        tbl[1] = mkv(1, 2'b00, 5'd5, 32'h55, 0, 1, 5'd5, 32'hAAAA_0001, 1, 5'd5, 32'hBBBB_0002,
                     32'hAAAA_0001, 32'hAAAA_0001, 2'b01);
        tbl[2] = mkv(1, 2'b00, 5'd0, 32'h0, 0, 1, 5'd0, 32'hDEAD_BEEF, 1, 5'd0, 32'h1,
                     32'h0, 32'h0, 2'b00);
        tbl[3] = mkv(1, 2'b01, 5'd7, 32'h77, 32'h10, 1, 5'd8, 32'h99, 1, 5'd7, 32'h1234_5678,
                     32'h10, 32'h1234_5678, 2'b10);
        tbl[4] = mkv(1, 2'b10, 5'd2, 32'h22, 32'h5, 0, 5'd2, 32'h3, 0, 5'd2, 32'h3,
                     32'h4, 32'h22, 2'b00);
        tbl[5] = mkv(1, 2'b11, 5'd9, 32'h9, 32'h5, 1, 5'd9, 32'hCAFE, 0, 5'd0, 0,
                     32'h0, 32'hCAFE, 2'b01);
        tbl[6] = mkv(1, 2'b00, 5'd4, 32'h40, 0, 0, 5'd4, 32'h1, 1, 5'd4, 32'h4444,
                     32'h4444, 32'h4444, 2'b10);
        tbl[7] = mkv(0, 2'b00, 5'd6, 32'h60, 0, 1, 5'd6, 32'h66, 0, 5'd0, 0,
                     32'h66, 32'h66, 2'b01);

        for (int i = 0; i < 8; i++) begin
            quiet();
            in_valid = tbl[i].v; aluBSrc = tbl[i].src; rs2_addr = tbl[i].rs2;
            ru_rs2 = tbl[i].ru; immgen = tbl[i].imm;
            exmem_wen = tbl[i].exw; exmem_rd = tbl[i].exrd; exmem_result = tbl[i].exr;
            memwb_wen = tbl[i].mww; memwb_rd = tbl[i].mwrd; memwb_result = tbl[i].mwr;
            model_edge();
            @(posedge clk); #1;
            chk($sformatf("vec%0d.aluB", i), aluB, tbl[i].e_alub);
            chk($sformatf("vec%0d.store_data", i), store_data, tbl[i].e_sd);
            chk($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].v});
            chk($sformatf("vec%0d.fwd_sel", i), {30'd0, fwd_sel}, {30'd0, tbl[i].e_sel});
            chk($sformatf("vec%0d.fwd_cnt", i), {28'd0, fwd_cnt}, m_cnt);
        end
        chk("vec.cnt_total", {28'd0, fwd_cnt}, FWD ? 4 : 0);

        // Load constant 4, then stall three cycles with changing inputs.
        quiet();
        in_valid = 1; aluBSrc = 2'b10; rs2_addr = 5'd1; ru_rs2 = 32'h1;
        edge_chk("st_load");
        chk("st_load.aluB4", aluB, 4);
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            stall = 1;
            edge_chk("stall");
            chk("stall.aluB_held", aluB, 4);
            chk("stall.valid_held", {31'd0, out_valid}, 1);
        end
        stall = 1; flush = 1;
        edge_chk("stall_flush");
        chk("stall_flush.aluB", aluB, 0);
        chk("stall_flush.out_valid", {31'd0, out_valid}, 0);

        // Counter: clear, saturate, then clear racing a forward event.
        quiet();
        cnt_clr = 1;
        edge_chk("clr");
        chk("clr.cnt0", {28'd0, fwd_cnt}, 0);
        for (int i = 0; i < 17; i++) begin
            set_fwd_load(5'd5, 32'h100 + i);
            edge_chk("sat");
        end
        chk("sat.cnt_f", {28'd0, fwd_cnt}, FWD ? 15 : 0);
        chk("sat.sel", {30'd0, fwd_sel}, FWD ? 1 : 0);
        set_fwd_load(5'd3, 32'h3333);
        cnt_clr = 1;
        edge_chk("clr_race");
        chk("clr_race.cnt", {28'd0, fwd_cnt}, 0);

        // Asynchronous reset while stalled.
        quiet();
        in_valid = 1; aluBSrc = 2'b01; immgen = 32'h77;
        edge_chk("pre_rst");
        stall = 1;
        #2;
        rst_n = 0;
        #1;
        chk("rst_mid.aluB", aluB, 0);
        chk("rst_mid.out_valid", {31'd0, out_valid}, 0);
        chk("rst_mid.fwd_cnt", {28'd0, fwd_cnt}, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        stall = 0; immgen = 32'h20;
        edge_chk("post_rst");
        chk("post_rst.aluB", aluB, 32'h20);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            stall   = ($urandom_range(0, 4) == 0);
            flush   = ($urandom_range(0, 9) == 0);
            cnt_clr = ($urandom_range(0, 29) == 0);
            edge_chk("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
